paddle_bank: RTL

Multi-channel paddle position controller for the Pong game core, sitting between the input/debounce logic and the renderer/collision logic. It holds NUM_PADDLES vertical paddle positions and moves each one on a frame tick. Held buttons accelerate from a slow to a fast speed, and every position is clamped exactly to the playfield. An optional compiled-in CPU mode lets any paddle track the ball.

---
 rtl/pong_pkg.sv | 15 +
 rtl/paddle_axis.sv | 113 +++++++++++
 rtl/paddle_bank.sv | 57 +++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong playfield constants and paddle FSM state encoding.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SLOW,
    FAST
  } paddle_state_t;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int MAX_V = 240;
  localparam int MAX_H = 320;

endpackage

// File: rtl/paddle_axis.sv
// Single paddle: request decode, accelerating move FSM and exact playfield clamp.
// Optional CPU tracking of the ball is compiled in with PADDLE_AI_EN.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int HEIGHT      = 20,
  parameter int MIN_V       = 0,
  parameter int MAX_V       = pong_pkg::MAX_V,
  parameter int START_V     = (MIN_V + MAX_V - HEIGHT) / 2,
  parameter int SPEED_SLOW  = 1,
  parameter int SPEED_FAST  = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int AI_DEADBAND = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           tick,
  input  logic           up,
  input  logic           down,
  input  logic           ai_mode,
  input  logic [Y_W-1:0] ball_y,
  output logic [Y_W-1:0] y,
  output logic           moving,
  output logic           at_limit
);

  localparam logic [9:0]     MIN_Y  = 10'(MIN_V);
  localparam logic [9:0]     TOP_Y  = 10'(MAX_V - HEIGHT);
  localparam logic [9:0]     SLOW_S = 10'(SPEED_SLOW);
  localparam logic [9:0]     FAST_S = 10'(SPEED_FAST);
  localparam logic [8:0]     ACCEL  = 9'(ACCEL_TICKS);
  localparam logic [Y_W-1:0] START  = Y_W'(START_V);

  paddle_state_t state;
  logic [7:0]    cnt;
  logic          dir_up;
  logic          req_up;
  logic          req_dn;
  logic          ai_sel;
  logic [9:0]    y_slow;
  logic [9:0]    y_fast;
  logic [8:0]    cnt_inc;

  function automatic logic [9:0] step_pos(input logic [9:0] cur, input logic go_up,
                                          input logic [9:0] step);
    logic [9:0] sum;
    sum = cur + step;
    if (go_up) return (sum > TOP_Y) ? TOP_Y : sum;
    return (cur < MIN_Y + step) ? MIN_Y : cur - step;
  endfunction

`ifdef PADDLE_AI_EN
  logic [9:0] centre;
  always_comb begin
    centre = {1'b0, y} + 10'(HEIGHT / 2);
    ai_sel = ai_mode;
    if (ai_mode) begin
      req_up = {1'b0, ball_y} > centre + 10'(AI_DEADBAND);
      // ball + deadband < centre avoids underflow near the bottom edge
      req_dn = {1'b0, ball_y} + 10'(AI_DEADBAND) < centre;
    end else begin
      req_up = up & ~down;
      req_dn = down & ~up;
    end
  end
`else
  logic ai_unused;
  assign ai_unused = ^{ai_mode, ball_y};
  always_comb begin
    ai_sel = 1'b0;
    req_up = up & ~down;
    req_dn = down & ~up;
  end
`endif

  always_comb begin
    y_slow  = step_pos({1'b0, y}, req_up, SLOW_S);
    y_fast  = step_pos({1'b0, y}, req_up, FAST_S);
    cnt_inc = {1'b0, cnt} + 9'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y      <= START;
      state  <= IDLE;
      cnt    <= '0;
      dir_up <= 1'b0;
      moving <= 1'b0;
    end else if (tick) begin
      if (!(req_up || req_dn)) begin
        state  <= IDLE;
        cnt    <= '0;
        moving <= 1'b0;
      end else if (state == IDLE || req_up != dir_up) begin
        y      <= y_slow[Y_W-1:0];
        cnt    <= 8'd1;
        dir_up <= req_up;
        state  <= (!ai_sel && ACCEL <= 9'd1) ? FAST : SLOW;
        moving <= 1'b1;
      end else if (state == FAST && !ai_sel) begin
        y <= y_fast[Y_W-1:0];
      end else begin
        // CPU control drops a FAST paddle back to SLOW and keeps it there
        y <= y_slow[Y_W-1:0];
        if (cnt != '1) cnt <= cnt_inc[7:0];
        state <= (!ai_sel && cnt_inc >= ACCEL) ? FAST : SLOW;
      end
    end
  end

  assign at_limit = (y == MIN_Y[Y_W-1:0]) || (y == TOP_Y[Y_W-1:0]);

endmodule

// File: rtl/paddle_bank.sv
// Bank of NUM_PADDLES paddle_axis channels with packed outputs and fixed x positions.
// CPU paddle tracking is enabled by defining PADDLE_AI_EN.
module paddle_bank
  import pong_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int HEIGHT      = 20,
  parameter int MIN_V       = 0,
  parameter int MAX_V       = pong_pkg::MAX_V,
  parameter int START_V     = (MIN_V + MAX_V - HEIGHT) / 2,
  parameter int X_BASE      = 8,
  parameter int X_STEP      = 300,
  parameter int SPEED_SLOW  = 1,
  parameter int SPEED_FAST  = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int AI_DEADBAND = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NUM_PADDLES-1:0]       up,
  input  logic [NUM_PADDLES-1:0]       down,
  input  logic [NUM_PADDLES-1:0]       ai_mode,
  input  logic [Y_W-1:0]               ball_y,
  output logic [NUM_PADDLES*X_W-1:0]   paddle_x,
  output logic [NUM_PADDLES*Y_W-1:0]   paddle_y,
  output logic [NUM_PADDLES-1:0]       moving,
  output logic [NUM_PADDLES-1:0]       at_limit
);

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_paddle
    assign paddle_x[X_W*i +: X_W] = X_W'(X_BASE + i * X_STEP);

    paddle_axis #(
      .HEIGHT     (HEIGHT),
      .MIN_V      (MIN_V),
      .MAX_V      (MAX_V),
      .START_V    (START_V),
      .SPEED_SLOW (SPEED_SLOW),
      .SPEED_FAST (SPEED_FAST),
      .ACCEL_TICKS(ACCEL_TICKS),
      .AI_DEADBAND(AI_DEADBAND)
    ) u_axis (
      .clock   (clock),
      .reset   (reset),
      .tick    (tick),
      .up      (up[i]),
      .down    (down[i]),
      .ai_mode (ai_mode[i]),
      .ball_y  (ball_y),
      .y       (paddle_y[Y_W*i +: Y_W]),
      .moving  (moving[i]),
      .at_limit(at_limit[i])
    );
  end

endmodule
